sync_edge_filter: RTL and testbench

//  Consumes the single-bit output of a signal_sync synchronizer in the same clk domain.

---
 rtl/sync_edge_filter.sv | 142 ++++++++++++++
 tb/tb_sync_edge_filter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_edge_filter.sv
// sync_edge_filter
// Debounces an already-synchronized single-bit level. A new level is accepted
// only after filt_len_g consecutive samples of the opposite level. The block
// provides the filtered level, one-cycle rise/fall pulses and a saturating
// count of accepted rising transitions with a sticky overflow flag.
module sync_edge_filter #(
    parameter logic polarity_g = 1'b0,
    parameter int   filt_len_g = 4,
    parameter int   cnt_w_g    = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sync_in,
    input  logic               en,
    input  logic               cnt_clr,
    output logic               lvl_out,
    output logic               rise_p,
    output logic               fall_p,
    output logic [cnt_w_g-1:0] evt_cnt,
    output logic               evt_ovf
);

    typedef enum logic [1:0] {
        STABLE_LO,
        QUAL_HI,
        STABLE_HI,
        QUAL_LO
    } state_t;

    localparam state_t             ResetState   = polarity_g ? STABLE_HI : STABLE_LO;
    localparam logic [7:0]         LastCnt      = 8'(filt_len_g - 1);
    localparam bit                 DirectSwitch = (filt_len_g == 1);
    localparam logic [cnt_w_g-1:0] CntMax       = '1;
    localparam logic [cnt_w_g-1:0] CntOne       = cnt_w_g'(1);

    state_t     r_state;
    logic [7:0] r_fcnt;

    logic w_rise_acc;
    logic w_fall_acc;

    // Decide whether this edge completes a qualification, so the FSM and the
    // event counter agree on exactly the same edge.
    always_comb begin
        w_rise_acc = 1'b0;
        w_fall_acc = 1'b0;
        if (en && sync_in) begin
            w_rise_acc = (r_state == STABLE_LO && DirectSwitch) ||
                         (r_state == QUAL_HI && r_fcnt == LastCnt);
        end
        if (en && !sync_in) begin
            w_fall_acc = (r_state == STABLE_HI && DirectSwitch) ||
                         (r_state == QUAL_LO && r_fcnt == LastCnt);
        end
    end

    // Qualification FSM with registered level and edge pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ResetState;
            r_fcnt  <= 8'd0;
            lvl_out <= polarity_g;
            rise_p  <= 1'b0;
            fall_p  <= 1'b0;
        end else begin
            rise_p <= 1'b0;
            fall_p <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (w_rise_acc) begin
                        r_state <= STABLE_HI;
                        r_fcnt  <= 8'd0;
                        lvl_out <= 1'b1;
                        rise_p  <= 1'b1;
                    end else if (en && sync_in) begin
                        r_state <= QUAL_HI;
                        r_fcnt  <= 8'd1;
                    end
                end
                QUAL_HI: begin
                    if (!en || !sync_in) begin
                        r_state <= STABLE_LO;
                        r_fcnt  <= 8'd0;
                    end else if (w_rise_acc) begin
                        r_state <= STABLE_HI;
                        r_fcnt  <= 8'd0;
                        lvl_out <= 1'b1;
                        rise_p  <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + 8'd1;
                    end
                end
                STABLE_HI: begin
                    if (w_fall_acc) begin
                        r_state <= STABLE_LO;
                        r_fcnt  <= 8'd0;
                        lvl_out <= 1'b0;
                        fall_p  <= 1'b1;
                    end else if (en && !sync_in) begin
                        r_state <= QUAL_LO;
                        r_fcnt  <= 8'd1;
                    end
                end
                QUAL_LO: begin
                    if (!en || sync_in) begin
                        r_state <= STABLE_HI;
                        r_fcnt  <= 8'd0;
                    end else if (w_fall_acc) begin
                        r_state <= STABLE_LO;
                        r_fcnt  <= 8'd0;
                        lvl_out <= 1'b0;
                        fall_p  <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ResetState;
                    r_fcnt  <= 8'd0;
                end
            endcase
        end
    end

    // Saturating rising-event counter; a clear wins over a same-edge event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_cnt <= '0;
            evt_ovf <= 1'b0;
        end else if (cnt_clr) begin
            evt_cnt <= '0;
            evt_ovf <= 1'b0;
        end else if (w_rise_acc) begin
            if (evt_cnt == CntMax) begin
                evt_ovf <= 1'b1;
            end else begin
                evt_cnt <= evt_cnt + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_sync_edge_filter.sv
// tb_sync_edge_filter
// Directed bench for sync_edge_filter: default instance driven from a vector
// table, plus hand-written sequences for reset, enable hold, counter
// saturation (narrow counter) and single-sample filtering with high polarity.
module tb_sync_edge_filter;

    logic clk;
    logic rstn;

    logic       syncA, enA, clrA, lvlA, riseA, fallA, ovfA;
    logic [7:0] cntA;
    logic       syncB, enB, clrB, lvlB, riseB, fallB, ovfB;
    logic [1:0] cntB;
    logic       syncC, enC, clrC, lvlC, riseC, fallC, ovfC;
    logic [7:0] cntC;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic       s;
        logic       e;
        logic       c;
        logic       lvl;
        logic       rise;
        logic       fall;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    sync_edge_filter dutA (
        .clk(clk), .rstn(rstn), .sync_in(syncA), .en(enA), .cnt_clr(clrA),
        .lvl_out(lvlA), .rise_p(riseA), .fall_p(fallA), .evt_cnt(cntA), .evt_ovf(ovfA)
    );

    sync_edge_filter #(.cnt_w_g(2)) dutB (
        .clk(clk), .rstn(rstn), .sync_in(syncB), .en(enB), .cnt_clr(clrB),
        .lvl_out(lvlB), .rise_p(riseB), .fall_p(fallB), .evt_cnt(cntB), .evt_ovf(ovfB)
    );

    sync_edge_filter #(.polarity_g(1'b1), .filt_len_g(1)) dutC (
        .clk(clk), .rstn(rstn), .sync_in(syncC), .en(enC), .cnt_clr(clrC),
        .lvl_out(lvlC), .rise_p(riseC), .fall_p(fallC), .evt_cnt(cntC), .evt_ovf(ovfC)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic e, input logic c);
        syncA = s;
        enA   = e;
        clrA  = c;
        tick();
    endtask

    task automatic addVec(input logic s, input logic e, input logic c, input logic lvl,
                          input logic rise, input logic fall, input logic [7:0] cnt);
        vec_t v;
        v.s = s; v.e = e; v.c = c; v.lvl = lvl; v.rise = rise; v.fall = fall; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Main directed test sequence.
    initial begin
        int mCnt;
        int mOvf;

        // Vector table for the default instance, applied after the reset test.
        addVec(0,1,0, 0,0,0,0);
        // Clean rise after four samples, then clean fall.
        addVec(1,1,0, 0,0,0,0);
        addVec(1,1,0, 0,0,0,0);
        addVec(1,1,0, 0,0,0,0);
        addVec(1,1,0, 1,1,0,1);
        addVec(1,1,0, 1,0,0,1);
        addVec(0,1,0, 1,0,0,1);
        addVec(0,1,0, 1,0,0,1);
        addVec(0,1,0, 1,0,0,1);
        addVec(0,1,0, 0,0,1,1);
        addVec(0,1,0, 0,0,0,1);
        // Three-sample glitch is rejected.
        addVec(1,1,0, 0,0,0,1);
        addVec(1,1,0, 0,0,0,1);
        addVec(1,1,0, 0,0,0,1);
        addVec(0,1,0, 0,0,0,1);
        // A mismatching sample restarts the count.
        addVec(1,1,0, 0,0,0,1);
        addVec(1,1,0, 0,0,0,1);
        addVec(0,1,0, 0,0,0,1);
        addVec(1,1,0, 0,0,0,1);
        addVec(1,1,0, 0,0,0,1);
        addVec(1,1,0, 0,0,0,1);
        addVec(1,1,0, 1,1,0,2);
        // Dropping enable mid-qualification aborts it; count restarts at 1.
        addVec(0,1,0, 1,0,0,2);
        addVec(0,1,0, 1,0,0,2);
        addVec(0,0,0, 1,0,0,2);
        addVec(0,1,0, 1,0,0,2);
        addVec(0,1,0, 1,0,0,2);
        addVec(0,1,0, 1,0,0,2);
        addVec(0,1,0, 0,0,1,2);
        // Clear, then a clear coincident with a rise loses the event.
        addVec(0,1,1, 0,0,0,0);
        addVec(1,1,0, 0,0,0,0);
        addVec(1,1,0, 0,0,0,0);
        addVec(1,1,0, 0,0,0,0);
        addVec(1,1,1, 1,1,0,0);
        addVec(1,1,0, 1,0,0,0);

        rstn  = 1'b0;
        syncA = 1'b0; enA = 1'b1; clrA = 1'b0;
        syncB = 1'b0; enB = 1'b1; clrB = 1'b0;
        syncC = 1'b1; enC = 1'b1; clrC = 1'b0;

        #12;
        checkOutput("rstA_lvl", 32'(lvlA), 32'd0);
        checkOutput("rstA_cnt", 32'(cntA), 32'd0);
        checkOutput("rstA_ovf", 32'(ovfA), 32'd0);
        checkOutput("rstA_pulses", 32'({riseA, fallA}), 32'd0);
        checkOutput("rstB_cnt", 32'(cntB), 32'd0);
        checkOutput("rstC_lvl", 32'(lvlC), 32'd1);
        checkOutput("rstC_pulses", 32'({riseC, fallC}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Reset in the middle of a rising qualification discards it.
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("midrst_lvl", 32'(lvlA), 32'd0);
        checkOutput("midrst_rise", 32'(riseA), 32'd0);
        checkOutput("midrst_cnt", 32'(cntA), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        checkOutput("postrst_lvl", 32'(lvlA), 32'd0);
        checkOutput("postrst_rise", 32'(riseA), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s, vecs[i].e, vecs[i].c);
            checkOutput($sformatf("vec%0d_lvl", i), 32'(lvlA), 32'(vecs[i].lvl));
            checkOutput($sformatf("vec%0d_rise", i), 32'(riseA), 32'(vecs[i].rise));
            checkOutput($sformatf("vec%0d_fall", i), 32'(fallA), 32'(vecs[i].fall));
            checkOutput($sformatf("vec%0d_cnt", i), 32'(cntA), 32'(vecs[i].cnt));
        end

        // Enable low while the input toggles: everything frozen.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i[0], 0, 0);
            checkOutput("enoff_lvl", 32'(lvlA), 32'd1);
            checkOutput("enoff_pulses", 32'({riseA, fallA}), 32'd0);
            checkOutput("enoff_cnt", 32'(cntA), 32'd0);
        end

        // Narrow counter saturates at all-ones and sets the sticky overflow.
        mCnt = 0;
        mOvf = 0;
        for (int r = 0; r < 5; r++) begin
            syncB = 1'b1;
            repeat (4) tick();
            if (mCnt == 3) mOvf = 1;
            else mCnt++;
            checkOutput($sformatf("satB%0d_rise", r), 32'(riseB), 32'd1);
            checkOutput($sformatf("satB%0d_cnt", r), 32'(cntB), 32'(mCnt));
            checkOutput($sformatf("satB%0d_ovf", r), 32'(ovfB), 32'(mOvf));
            syncB = 1'b0;
            repeat (4) tick();
        end
        syncB = 1'b1;
        repeat (3) tick();
        clrB = 1'b1;
        tick();
        checkOutput("clrB_rise", 32'(riseB), 32'd1);
        checkOutput("clrB_cnt", 32'(cntB), 32'd0);
        checkOutput("clrB_ovf", 32'(ovfB), 32'd0);
        clrB = 1'b0;
        tick();
        checkOutput("clrB_after_cnt", 32'(cntB), 32'd0);
        checkOutput("clrB_after_rise", 32'(riseB), 32'd0);

        // High-polarity, single-sample filter switches on the first sample.
        syncC = 1'b0;
        tick();
        checkOutput("c_fall_lvl", 32'(lvlC), 32'd0);
        checkOutput("c_fall_p", 32'(fallC), 32'd1);
        tick();
        checkOutput("c_hold_fall", 32'(fallC), 32'd0);
        checkOutput("c_hold_lvl", 32'(lvlC), 32'd0);
        syncC = 1'b1;
        tick();
        checkOutput("c_rise_p", 32'(riseC), 32'd1);
        checkOutput("c_rise_lvl", 32'(lvlC), 32'd1);
        checkOutput("c_rise_cnt", 32'(cntC), 32'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
